// File: rtl/decoder_pkg.sv
// Shared types and constants for the 2-to-4 decoder link.
package decoder_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  localparam logic [1:0] CODE_A = 2'b11;
  localparam logic [1:0] CODE_B = 2'b10;
  localparam logic [1:0] CODE_C = 2'b01;
  localparam logic [1:0] CODE_D = 2'b00;

  localparam int unsigned MAX_HOLD = 255;

  // One-hot result ordered {a, b, c, d}.
  function automatic logic [3:0] decode_code(input logic [1:0] code);
    logic [3:0] lines;
    lines = '0;
    case (code)
      CODE_A:  lines = 4'b1000;
      CODE_B:  lines = 4'b0100;
      CODE_C:  lines = 4'b0010;
      default: lines = 4'b0001;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/decoder_if.sv
// Encoded-code input and one-hot output bundle; p/err exist only with DECODER_PARITY_EN.
interface decoder_if;
  logic in_valid;
  logic in_ready;
  logic x;
  logic y;
  logic a;
  logic b;
  logic c;
  logic d;
  logic out_valid;
`ifdef DECODER_PARITY_EN
  logic p;
  logic err;

  modport master (
    output in_valid, x, y, p,
    input  in_ready, a, b, c, d, out_valid, err
  );

  modport slave (
    input  in_valid, x, y, p,
    output in_ready, a, b, c, d, out_valid, err
  );
`else
  modport master (
    output in_valid, x, y,
    input  in_ready, a, b, c, d, out_valid
  );

  modport slave (
    input  in_valid, x, y,
    output in_ready, a, b, c, d, out_valid
  );
`endif
endinterface

// File: rtl/decoder_hold_timer.sv
// Down-counter timing one strobe: load sets HOLD_CYCLES-1, en decrements, last flags zero.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/decoder.sv
// Sequential 2-to-4 decoder emitting a timed one-hot strobe per accepted code.
// Optional even-parity check enabled by DECODER_PARITY_EN.
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  decoder_if.slave   bus
);

  state_t     state, state_nx;
  logic [3:0] lines, lines_nx;
  logic       last;
  logic       accept;
  logic       load;

  assign bus.in_ready = !rst && ((state == ST_IDLE) || last);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef DECODER_PARITY_EN
  logic perr;
  logic err_q;

  // A parity-failing code completes the handshake but is treated as no code at all.
  assign perr    = accept && (bus.p != (bus.x ^ bus.y));
  assign load    = accept && !perr;
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= perr;
  end
`else
  assign load = accept;
`endif

  always_comb begin
    state_nx = state;
    lines_nx = lines;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nx = ST_HOLD;
          lines_nx = decode_code({bus.x, bus.y});
        end
      end
      ST_HOLD: begin
        if (last) begin
          if (load) begin
            lines_nx = decode_code({bus.x, bus.y});
          end else begin
            state_nx = ST_IDLE;
            lines_nx = '0;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        lines_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lines <= '0;
    end else begin
      state <= state_nx;
      lines <= lines_nx;
    end
  end

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(load),
    .en  (state == ST_HOLD),
    .last(last)
  );

  assign {bus.a, bus.b, bus.c, bus.d} = lines;
  assign bus.out_valid                = |lines;

endmodule

// File: tb/tb_decoder.sv
// Randomized self-checking bench for decoder against a strobe-window reference model.
module tb_decoder;

  localparam int unsigned H4 = 4;
`ifdef DECODER_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst4;
  logic rst1;
  always #5 clk = ~clk;

  decoder_if bus4 ();
  decoder_if bus1 ();

  decoder #(.HOLD_CYCLES(H4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  decoder #(.HOLD_CYCLES(1))  dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Model: a strobe of code m_code covers cycles up to m_busy; cycle m_t is the current one.
  int         m_t    = 0;
  int         m_busy = -1;
  logic [1:0] m_code = '0;
  logic       m_err  = 1'b0;

  function automatic logic [3:0] line_of(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  task automatic cycle4(input logic r, input logic v, input logic [1:0] code,
                        input logic par_ok, output logic acc);
    logic [3:0] exp_lines;
    logic [3:0] got;
    logic       exp_ready;
    logic       ok;
    @(negedge clk);
    rst4          = r;
    bus4.in_valid = v;
    bus4.x        = code[1];
    bus4.y        = code[0];
`ifdef DECODER_PARITY_EN
    bus4.p = code[1] ^ code[0] ^ ~par_ok;
`endif
    #1;
    exp_ready = !r && (m_t >= m_busy);
    exp_lines = (m_t <= m_busy) ? line_of(m_code) : 4'b0000;
    got       = {bus4.a, bus4.b, bus4.c, bus4.d};
    checks++;
    if (got !== exp_lines) begin
      errors++;
      $display("FAIL lines cycle %0d: got %b want %b", m_t, got, exp_lines);
    end
    checks++;
    if (bus4.out_valid !== (|exp_lines)) begin
      errors++;
      $display("FAIL out_valid cycle %0d: got %b want %b", m_t, bus4.out_valid, |exp_lines);
    end
    checks++;
    if (bus4.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready cycle %0d: got %b want %b", m_t, bus4.in_ready, exp_ready);
    end
`ifdef DECODER_PARITY_EN
    checks++;
    if (bus4.err !== m_err) begin
      errors++;
      $display("FAIL err cycle %0d: got %b want %b", m_t, bus4.err, m_err);
    end
`endif
    @(posedge clk);
    acc   = v && exp_ready;
    ok    = par_ok || !PARITY;
    m_err = 1'b0;
    if (r) begin
      m_busy = m_t;
    end else if (acc) begin
      if (ok) begin
        m_code = code;
        m_busy = m_t + int'(H4);
      end else begin
        m_err = 1'b1;
      end
    end
    m_t++;
  endtask

  task automatic idle4(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle4(1'b0, 1'b0, 2'($urandom), 1'b1, acc);
  endtask

  task automatic send4(input logic [1:0] code, input logic par_ok, input string name);
    logic acc;
    int   tries;
    tries = 0;
    do begin
      cycle4(1'b0, 1'b1, code, par_ok, acc);
      tries++;
    end while (!acc && tries < 20);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s accept: got none within %0d cycles want accept", name, tries);
    end
  endtask

  task automatic test_reset();
    logic acc;
    cycle4(1'b1, 1'b1, 2'b11, 1'b1, acc);
    cycle4(1'b1, 1'b1, 2'b10, 1'b1, acc);
    idle4(3);
  endtask

  task automatic test_single();
    send4(2'b10, 1'b1, "single_b");
    idle4(6);
  endtask

  task automatic test_back_to_back();
    send4(2'b11, 1'b1, "stream_a");
    send4(2'b01, 1'b1, "stream_c");
    send4(2'b00, 1'b1, "stream_d");
    idle4(6);
  endtask

  task automatic test_reset_mid();
    logic acc;
    send4(2'b01, 1'b1, "mid_c");
    cycle4(1'b0, 1'b0, 2'b00, 1'b1, acc);
    cycle4(1'b1, 1'b1, 2'b11, 1'b1, acc);
    idle4(3);
  endtask

  task automatic test_parity();
`ifdef DECODER_PARITY_EN
    send4(2'b11, 1'b0, "parity_bad");
    idle4(2);
    send4(2'b11, 1'b1, "parity_good");
    idle4(6);
`endif
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 400; i++) begin
      cycle4(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 2'($urandom),
             ($urandom_range(0, 3) != 0), acc);
    end
    idle4(6);
  endtask

  task automatic test_hold1();
    logic [1:0] seq [4];
    logic [3:0] got;
    logic [3:0] want;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11;
    @(negedge clk);
    rst1 = 1'b1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    rst1 = 1'b0;
    for (int unsigned i = 0; i <= 4; i++) begin
      if (i < 4) begin
        bus1.in_valid = 1'b1;
        bus1.x = seq[i][1];
        bus1.y = seq[i][0];
`ifdef DECODER_PARITY_EN
        bus1.p = seq[i][1] ^ seq[i][0];
`endif
      end else begin
        bus1.in_valid = 1'b0;
      end
      #1;
      want = (i == 0) ? 4'b0000 : line_of(seq[i-1]);
      got  = {bus1.a, bus1.b, bus1.c, bus1.d};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold1 lines step %0d: got %b want %b", i, got, want);
      end
      checks++;
      if (bus1.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL hold1 in_ready step %0d: got %b want 1", i, bus1.in_ready);
      end
      @(negedge clk);
    end
    #1;
    got = {bus1.a, bus1.b, bus1.c, bus1.d};
    checks++;
    if (got !== 4'b0000 || bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold1 drain: got %b/%b want 0000/0", got, bus1.out_valid);
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;
    bus4.in_valid = 1'b0; bus4.x = 1'b0; bus4.y = 1'b0;
    bus1.in_valid = 1'b0; bus1.x = 1'b0; bus1.y = 1'b0;
`ifdef DECODER_PARITY_EN
    bus4.p = 1'b0;
    bus1.p = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    test_random();
    test_hold1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decoder.md
# decoder

Sequential 2-to-4 decoder, the receiving end of the team's 4-to-2 priority-free encoder link.

- Accepts one encoded 2-bit code (x,y) per valid/ready handshake.
- Drives the matching one-hot line (a,b,c,d) as a registered output for a fixed number of cycles.
- Sits between the encoder's output bus and the downstream indicator/actuator logic that needs a stable, timed one-hot strobe.

## Interface
- HOLD_CYCLES, 4: cycles each decoded one-hot output stays asserted. Legal range is 1..255.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  encoded code is present on x,y.
- in_ready  output  1  decoder can accept a code this cycle.
- x  input  1  encoded MSB.
- y  input  1  encoded LSB.
- p  input  1  even-parity bit, present only with DECODER_PARITY_EN.
- a, b, c, d  output  1 each  registered one-hot decoded lines.
- out_valid  output  1  one of a..d is asserted.
- err  output  1  parity-error pulse, present only with DECODER_PARITY_EN.

## Operation
- Code map, matching the encoder:
  - xy=11 -> a
  - xy=10 -> b
  - xy=01 -> c
  - xy=00 -> d
- A code is accepted on any clk edge where in_valid && in_ready && !rst.
- FSM has two states, IDLE and HOLD.
  - IDLE: a..d=0, out_valid=0, in_ready=1. An accept loads the one-hot register, sets cnt=HOLD_CYCLES-1 and moves to HOLD.
  - HOLD, cnt>0: outputs hold their value, cnt decrements, in_ready=0.
  - HOLD, cnt==0 (last hold cycle): in_ready=1.
    - On accept, the new one-hot is loaded, cnt reloads and the FSM stays in HOLD, giving back-to-back strobes with no gap.
    - With no accept, the FSM goes to IDLE and outputs drop to 0.
- Exactly one of a..d is high whenever out_valid=1. out_valid equals a|b|c|d.
- Input codes are sampled only on accept. x,y changing outside an accept has no effect.
- The counter is ceil(log2(HOLD_CYCLES)) bits, minimum 1. It never underflows, because a decrement occurs only when cnt>0.

## Timing
- Latency: accept at edge N means the one-hot line is high from edge N (visible in cycle N+1) through cycle N+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: in_ready stays 1 continuously, so the decoder sustains one code per cycle.
- in_ready is combinational from state and cnt, and is forced 0 while rst=1.
- Reset values:
  - a, b, c, d, out_valid, err = 0.
  - State IDLE, cnt=0.
- Reset asserted mid-HOLD: at the next edge all outputs are 0 and the FSM is in IDLE. A simultaneous in_valid is ignored.
- Throughput: one code per HOLD_CYCLES cycles.

## Configuration
- Macro DECODER_PARITY_EN.
- Defined:
  - Ports p and err exist.
  - An accepted code with p != x^y is discarded and err pulses high for exactly one cycle after the accept edge.
  - The discard behaves as a non-accept for the FSM: from IDLE it stays IDLE; from the last HOLD cycle it goes to IDLE and outputs drop.
  - Handshake timing is unchanged.
- Undefined: p and err are absent and every accepted code is decoded.

## Structure
- Package decoder_pkg holds:
  - State enum: ST_IDLE, ST_HOLD.
  - Code constants: CODE_A=2'b11, CODE_B=2'b10, CODE_C=2'b01, CODE_D=2'b00.
  - MAX_HOLD=255.
- One sub-module, hold_timer, contains the load/decrement counter with HOLD_CYCLES as a parameter. It has inputs load and en, and output last (cnt==0).
- FSM, one-hot register and parity check live in decoder.

## Test plan
- Reset then idle, HOLD_CYCLES=4 -> a..d=0, out_valid=0, in_ready=1, err=0.
- Accept xy=10, then hold in_valid=0 -> b=1 for exactly 4 cycles, in_ready=0 for the first 3 of them, then all outputs 0.
- Stream 11,01,00 with in_valid held high -> a, c, d strobes of 4 cycles each with no gap between them; in_ready pulses only on each last hold cycle.
- rst asserted in the 2nd cycle of a c strobe -> all outputs 0 at the next edge and FSM in IDLE; in_valid during rst is ignored.
- DECODER_PARITY_EN: x=1, y=1, p=1 -> no strobe; err=1 for one cycle; then x=1, y=1, p=0 -> a strobe.
- HOLD_CYCLES=1: codes 00,01,10,11 on consecutive cycles -> d, c, b, a each high for one cycle, back-to-back.
